// File: rtl/common.sv
// -----------------------------------------------------------------------------
// common
// Shared types for the raster pipeline. raster_command_t is the opcode carried
// from the CPU command port through raster_cmd_queue to the rasterizer.
// -----------------------------------------------------------------------------
package common;

    typedef enum logic [2:0] {
        RC_NOP   = 3'd0,
        RC_CLEAR = 3'd1,
        RC_LINE  = 3'd2,
        RC_RECT  = 3'd3,
        RC_FILL  = 3'd4
    } raster_command_t;

endpackage

// File: rtl/raster_cmd_queue.sv
// -----------------------------------------------------------------------------
// raster_cmd_queue
// Register-based FIFO that buffers raster commands posted by the CPU and hands
// them to the rasterizer one at a time, so a burst of commands can be queued
// while the rasterizer is busy with a long operation.
//
// Parameters:
//   DEPTH    number of queued commands (power of two, >= 2)
//   LEVEL_W  width of level, derived from DEPTH
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push_valid/push_ready    CPU push handshake
//   push_command, push_colour, push_x0/y0/x1/y1   command fields to store
//   flush                    discard all queued commands
//   command, colour, x0/y0/x1/y1   head command presented to the rasterizer
//   execute_request          head is valid
//   gpu_ready                rasterizer takes the head this cycle
//   level                    number of stored commands (0..DEPTH)
//   overflow                 sticky: push attempted while push_ready was low
//
// Configuration macro:
//   RASTER_QUEUE_CLIP_EN     clamp x to 213 and y to 159 on push
// -----------------------------------------------------------------------------
module raster_cmd_queue #(
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  common::raster_command_t push_command,
    input  logic [2:0]             push_colour,
    input  logic [7:0]             push_x0,
    input  logic [7:0]             push_y0,
    input  logic [7:0]             push_x1,
    input  logic [7:0]             push_y1,
    input  logic                   flush,
    output common::raster_command_t command,
    output logic [2:0]             colour,
    output logic [7:0]             x0,
    output logic [7:0]             y0,
    output logic [7:0]             x1,
    output logic [7:0]             y1,
    output logic                   execute_request,
    input  logic                   gpu_ready,
    output logic [LEVEL_W-1:0]     level,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(DEPTH);

    typedef struct packed {
        common::raster_command_t command;
        logic [2:0]              colour;
        logic [7:0]              x0;
        logic [7:0]              y0;
        logic [7:0]              x1;
        logic [7:0]              y1;
    } entry_t;

`ifdef RASTER_QUEUE_CLIP_EN
    // Framebuffer is 214 x 160; out-of-range coordinates are pinned to the edge.
    function automatic logic [7:0] clip_x(input logic [7:0] v);
        return (v > 8'd213) ? 8'd213 : v;
    endfunction

    function automatic logic [7:0] clip_y(input logic [7:0] v);
        return (v > 8'd159) ? 8'd159 : v;
    endfunction
`endif

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LEVEL_W-1:0] count_r;
    logic               overflow_r;

    entry_t             push_entry_s;
    entry_t             head_s;
    logic               push_fire_s;
    logic               pop_fire_s;

    // Handshakes: push_ready deliberately ignores gpu_ready, so a full queue
    // refuses a push even in a cycle where it also pops.
    always_comb begin
        push_ready      = (count_r != LEVEL_MAX) & ~flush;
        execute_request = (count_r != {LEVEL_W{1'b0}});
        push_fire_s     = push_valid & push_ready;
        pop_fire_s      = execute_request & gpu_ready;
    end

    // Assemble the entry to be stored, optionally clipping coordinates.
    always_comb begin
        push_entry_s.command = push_command;
        push_entry_s.colour  = push_colour;
`ifdef RASTER_QUEUE_CLIP_EN
        push_entry_s.x0      = clip_x(push_x0);
        push_entry_s.y0      = clip_y(push_y0);
        push_entry_s.x1      = clip_x(push_x1);
        push_entry_s.y1      = clip_y(push_y1);
`else
        push_entry_s.x0      = push_x0;
        push_entry_s.y0      = push_y0;
        push_entry_s.x1      = push_x1;
        push_entry_s.y1      = push_y1;
`endif
    end

    // Head fields are a direct read of the oldest entry; rd_ptr only moves on
    // a pop, so they hold steady while execute_request waits for gpu_ready.
    always_comb begin
        head_s   = mem_r[rd_ptr_r];
        command  = head_s.command;
        colour   = head_s.colour;
        x0       = head_s.x0;
        y0       = head_s.y0;
        x1       = head_s.x1;
        y1       = head_s.y1;
        level    = count_r;
        overflow = overflow_r;
    end

    // Storage array write; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push_fire_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {LEVEL_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            // flush is excluded: a refused push during flush is not an overflow
            if (push_valid & ~push_ready & ~flush) begin
                overflow_r <= 1'b1;
            end
            if (flush) begin
                // A pop in this cycle was already latched by the rasterizer.
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {LEVEL_W{1'b0}};
            end else begin
                if (push_fire_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_fire_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                case ({push_fire_s, pop_fire_s})
                    2'b10:   count_r <= count_r + LEVEL_ONE;
                    2'b01:   count_r <= count_r - LEVEL_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_raster_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_raster_cmd_queue
// Self-checking bench for raster_cmd_queue (DEPTH = 8). A scoreboard queue
// holds the commands the bench expects to be stored; accepted pushes are
// appended, pops remove the head, and the DUT head, level, push_ready,
// execute_request and overflow are compared against it every cycle.
// -----------------------------------------------------------------------------
module tb_raster_cmd_queue;

    localparam int DEPTH   = 8;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        common::raster_command_t command;
        logic [2:0]              colour;
        logic [7:0]              x0;
        logic [7:0]              y0;
        logic [7:0]              x1;
        logic [7:0]              y1;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    push_valid = 1'b0;
    logic                    push_ready;
    common::raster_command_t push_command = common::RC_NOP;
    logic [2:0]              push_colour = 3'd0;
    logic [7:0]              push_x0 = 8'd0;
    logic [7:0]              push_y0 = 8'd0;
    logic [7:0]              push_x1 = 8'd0;
    logic [7:0]              push_y1 = 8'd0;
    logic                    flush = 1'b0;
    common::raster_command_t command;
    logic [2:0]              colour;
    logic [7:0]              x0;
    logic [7:0]              y0;
    logic [7:0]              x1;
    logic [7:0]              y1;
    logic                    execute_request;
    logic                    gpu_ready = 1'b0;
    logic [LEVEL_W-1:0]      level;
    logic                    overflow;

    ent_t        sb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned pops_seen   = 0;
    int unsigned pushes_seen = 0;
    logic        ovf_model   = 1'b0;

    raster_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .push_valid      (push_valid),
        .push_ready      (push_ready),
        .push_command    (push_command),
        .push_colour     (push_colour),
        .push_x0         (push_x0),
        .push_y0         (push_y0),
        .push_x1         (push_x1),
        .push_y1         (push_y1),
        .flush           (flush),
        .command         (command),
        .colour          (colour),
        .x0              (x0),
        .y0              (y0),
        .x1              (x1),
        .y1              (y1),
        .execute_request (execute_request),
        .gpu_ready       (gpu_ready),
        .level           (level),
        .overflow        (overflow)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] model_x(input logic [7:0] v);
`ifdef RASTER_QUEUE_CLIP_EN
        return (v > 8'd213) ? 8'd213 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] model_y(input logic [7:0] v);
`ifdef RASTER_QUEUE_CLIP_EN
        return (v > 8'd159) ? 8'd159 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input common::raster_command_t c, input logic [2:0] col,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] cc, input logic [7:0] d);
        push_command = c;
        push_colour  = col;
        push_x0      = a;
        push_y0      = b;
        push_x1      = cc;
        push_y1      = d;
    endtask

    task automatic set_rand();
        set_cmd(common::raster_command_t'(3'($urandom_range(0, 4))),
                3'($urandom_range(0, 7)),
                8'($urandom_range(0, 213)), 8'($urandom_range(0, 159)),
                8'($urandom_range(0, 213)), 8'($urandom_range(0, 159)));
    endtask

    // One clock of stimulus: drive just after posedge, check at negedge,
    // then advance the model by what the handshakes should have done.
    task automatic step(input logic pv, input logic gr, input logic fl);
        logic exp_exec;
        logic exp_ready;
        ent_t e;
        push_valid = pv;
        gpu_ready  = gr;
        flush      = fl;
        @(negedge clk);
        exp_exec  = (sb.size() != 0);
        exp_ready = (sb.size() != DEPTH) && !fl;
        chk("execute_request", 32'(execute_request), 32'(exp_exec));
        chk("push_ready", 32'(push_ready), 32'(exp_ready));
        chk("level", 32'(level), 32'(sb.size()));
        chk("overflow", 32'(overflow), 32'(ovf_model));
        if (exp_exec) begin
            chk("head_command", 32'(command), 32'(sb[0].command));
            chk("head_colour", 32'(colour), 32'(sb[0].colour));
            chk("head_x0", 32'(x0), 32'(sb[0].x0));
            chk("head_y0", 32'(y0), 32'(sb[0].y0));
            chk("head_x1", 32'(x1), 32'(sb[0].x1));
            chk("head_y1", 32'(y1), 32'(sb[0].y1));
        end
        if (exp_exec && gr) begin
            e = sb.pop_front();
            pops_seen++;
        end
        if (pv && !exp_ready && !fl) begin
            ovf_model = 1'b1;
        end
        if (pv && exp_ready) begin
            e.command = push_command;
            e.colour  = push_colour;
            e.x0      = model_x(push_x0);
            e.y0      = model_y(push_y0);
            e.x1      = model_x(push_x1);
            e.y1      = model_y(push_y1);
            sb.push_back(e);
            pushes_seen++;
        end
        if (fl) begin
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic gr);
        rst        = 1'b1;
        push_valid = 1'b0;
        gpu_ready  = gr;
        flush      = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        gpu_ready  = 1'b0;
        sb.delete();
        ovf_model  = 1'b0;
    endtask

    initial begin
        int unsigned phase_pops;
        int unsigned phase_pushes;

        // Reset and single command
        @(posedge clk);
        do_reset(1'b0);
        step(1'b0, 1'b0, 1'b0);
        set_cmd(common::RC_FILL, 3'b101, 8'd10, 8'd20, 8'd100, 8'd120);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Fill to full: ninth push refused, overflow sets
        for (int i = 0; i < 9; i++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);

        // Simultaneous push and pop at level 3, then refused push at full
        for (int i = 0; i < 3; i++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            set_rand();
            step(1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0);
        end
        set_rand();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Flush with pop at level 5, concurrent push refused
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        set_rand();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Pointer wrap-around with random push/pop pressure
        phase_pops   = pops_seen;
        phase_pushes = pushes_seen;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ((pushes_seen - phase_pushes) == 3 * DEPTH && sb.size() == 0) begin
                break;
            end
            set_rand();
            step(((pushes_seen - phase_pushes) < 3 * DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0,
                 1'($urandom_range(0, 1)), 1'b0);
        end
        chk("wrap_pushed", pushes_seen - phase_pushes, 32'(3 * DEPTH));
        chk("wrap_delivered", pops_seen - phase_pops, 32'(3 * DEPTH));

        // Clipping boundary values
        set_cmd(common::RC_LINE, 3'b010, 8'd250, 8'd200, 8'd214, 8'd160);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        set_cmd(common::RC_RECT, 3'b111, 8'd213, 8'd159, 8'd0, 8'd255);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Reset mid-operation discards entries and clears overflow
        for (int i = 0; i < 2; i++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0);
        end
        do_reset(1'b1);
        step(1'b0, 1'b0, 1'b0);
        set_rand();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
